// File: rtl/keypad_event_ctrl_pkg.sv
// Shared types for the keypad event sequencer: event record, FSM states, helpers.
package keypad_pkg;

    // Queued key event: repeat flag plus 0-based key index.
    typedef struct packed {
        logic       rpt;
        logic [3:0] code;
    } evt_t;

    typedef enum logic [1:0] {
        StIdle,
        StHeld,
        StRepeat
    } kst_t;

    localparam logic [4:0] KEY_NONE = 5'd0;

    // Build an event from a 1-based scanned key code.
    function automatic evt_t mk_evt(input logic rpt, input logic [4:0] key);
        evt_t e;
        e.rpt  = rpt;
        e.code = 4'(key - 5'd1);
        return e;
    endfunction

endpackage

// File: rtl/keypad_event_ctrl_if.sv
// Valid/ready event stream from the keypad sequencer to the timer core.
interface keypad_event_ctrl_if;

    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_code;
    logic       evt_rpt;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_rpt,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_rpt,
        output evt_ready
    );

endinterface

// File: rtl/keypad_event_ctrl_fifo.sv
// Show-ahead event FIFO; a push that finds no room is dropped and flagged.
module keypad_evt_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter type         evt_type_t = evt_t
) (
    input  logic      mclk,
    input  logic      rst_n,
    input  logic      i_push,
    input  evt_type_t i_push_data,
    input  logic      i_pop,
    output evt_type_t o_head,
    output logic      o_full,
    output logic      o_empty,
    output logic      o_drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    evt_type_t     r_mem [DEPTH];

    logic          w_pop;
    logic          w_wr;

    // Status, accept and drop decisions.
    always_comb begin
        o_empty = (r_wr_ptr == r_rd_ptr);
        o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_pop   = i_pop && !o_empty;
        // A pop in the same cycle frees the slot the push needs.
        w_wr    = i_push && (!o_full || w_pop);
        o_drop  = i_push && o_full && !w_pop;
        o_head  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    end

    // Pointer update.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; contents are don't-care while empty since the head is masked.
    always_ff @(posedge mclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/keypad_event_ctrl.sv
// Keypad event sequencer: debounces the scanned key code, emits press and
// auto-repeat events and queues them for the timer core.
module keypad_event_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 2048,
    parameter int unsigned REPEAT_DELAY = 4_000_000,
    parameter int unsigned REPEAT_RATE  = 1_000_000,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                   mclk,
    input  logic                   rst_n,
    input  logic [4:0]             i_key_code,
    input  logic                   i_rpt_en,
    input  logic                   i_ovf_clr,
    output logic                   o_key_held,
    output logic                   o_ovf,
    keypad_event_ctrl_if.master    evt_if
);

    localparam int unsigned StabW     = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [StabW-1:0] StabMax = StabW'(DEBOUNCE_CYC);
    localparam logic [23:0] DelayLast = 24'(REPEAT_DELAY - 1);
    localparam logic [23:0] RateLast  = 24'(REPEAT_RATE - 1);

    logic [4:0]       r_cand;
    logic [StabW-1:0] r_stab_cnt;
    logic             w_stable;

    kst_t             r_state;
    kst_t             w_state_nxt;
    logic [4:0]       r_hold;
    logic [4:0]       w_hold_nxt;
    logic [23:0]      r_rpt_cnt;
    logic [23:0]      w_rpt_cnt_nxt;
    logic [23:0]      w_rpt_last;

    logic             w_push;
    evt_t             w_push_evt;
    evt_t             w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_fifo_drop;
    logic             w_pop;
    logic             r_ovf;

    // Stability filter: count consecutive identical samples, saturating.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand     <= KEY_NONE;
            r_stab_cnt <= '0;
        end else if (i_key_code != r_cand) begin
            r_cand     <= i_key_code;
            r_stab_cnt <= '0;
        end else if (r_stab_cnt != StabMax) begin
            r_stab_cnt <= r_stab_cnt + 1'b1;
        end
    end

    assign w_stable = (r_stab_cnt == StabMax);

    // FSM state, held key and repeat timer.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_hold    <= KEY_NONE;
            r_rpt_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
        end
    end

    // Next-state and event generation.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_rpt_cnt_nxt = r_rpt_cnt;
        w_push        = 1'b0;
        w_push_evt    = '0;
        w_rpt_last    = (r_state == StRepeat) ? RateLast : DelayLast;
        case (r_state)
            StIdle: begin
                if (w_stable && (r_cand != KEY_NONE)) begin
                    w_push        = 1'b1;
                    w_push_evt    = mk_evt(1'b0, r_cand);
                    w_hold_nxt    = r_cand;
                    w_rpt_cnt_nxt = '0;
                    w_state_nxt   = StHeld;
                end
            end
            StHeld, StRepeat: begin
                // Release / rolling change takes priority over the repeat timer.
                if (w_stable && (r_cand != r_hold)) begin
                    if (r_cand == KEY_NONE) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_push        = 1'b1;
                        w_push_evt    = mk_evt(1'b0, r_cand);
                        w_hold_nxt    = r_cand;
                        w_rpt_cnt_nxt = '0;
                        w_state_nxt   = StHeld;
                    end
                end else if (i_rpt_en) begin
                    if (r_rpt_cnt == w_rpt_last) begin
                        w_push        = 1'b1;
                        w_push_evt    = mk_evt(1'b1, r_hold);
                        w_rpt_cnt_nxt = '0;
                        w_state_nxt   = StRepeat;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + 24'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign w_pop = !w_fifo_empty && evt_if.evt_ready;

    keypad_evt_fifo #(
        .DEPTH      (DEPTH),
        .evt_type_t (evt_t)
    ) u_fifo (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_evt),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_drop      (w_fifo_drop)
    );

    // Sticky overflow flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_fifo_drop && w_fifo_full) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Output drive.
    always_comb begin
        evt_if.evt_valid = !w_fifo_empty;
        evt_if.evt_code  = w_head.code;
        evt_if.evt_rpt   = w_head.rpt;
        o_key_held       = (r_state != StIdle);
        o_ovf            = r_ovf;
    end

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Self-checking bench for keypad_event_ctrl: directed scenarios plus random
// key streams, all compared against an event-level reference model.
module tb_keypad_event_ctrl;

    localparam int DEB   = 4;
    localparam int DLY   = 10;
    localparam int RATE  = 3;
    localparam int DEPTH = 4;

    logic       mclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] key_code = 5'd0;
    logic       rpt_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       key_held;
    logic       ovf;

    keypad_event_ctrl_if u_if ();

    keypad_event_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .REPEAT_DELAY (DLY),
        .REPEAT_RATE  (RATE),
        .DEPTH        (DEPTH)
    ) u_dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .i_key_code (key_code),
        .i_rpt_en   (rpt_en),
        .i_ovf_clr  (ovf_clr),
        .o_key_held (key_held),
        .o_ovf      (ovf),
        .evt_if     (u_if)
    );

    always #5 mclk = ~mclk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: run length of the sampled code, held key, repeat timer
    // measured in enabled cycles since the last event, and an event queue.
    int         m_cand;
    int         m_run;
    bit         m_held;
    int         m_hold;
    int         m_elapsed;
    int         m_period;
    bit         m_ovf;
    logic [4:0] q[$];

    function automatic void model_reset();
        m_cand = 0; m_run = 1; m_held = 0; m_hold = 0;
        m_elapsed = 0; m_period = DLY; m_ovf = 0;
        q.delete();
    endfunction

    function automatic void model_edge();
        bit         stable;
        bit         pop;
        bit         push;
        bit         drop;
        logic [4:0] ev;
        stable = (m_run > DEB);
        pop    = (q.size() > 0) && u_if.evt_ready;
        push   = 0;
        drop   = 0;
        ev     = '0;
        if ((!m_held && stable && m_cand != 0) ||
            (m_held && stable && m_cand != m_hold && m_cand != 0)) begin
            push = 1; ev = {1'b0, 4'(m_cand - 1)};
            m_held = 1; m_hold = m_cand; m_elapsed = 0; m_period = DLY;
        end else if (m_held && stable && m_cand == 0) begin
            m_held = 0;
        end else if (m_held && rpt_en) begin
            m_elapsed++;
            if (m_elapsed == m_period) begin
                push = 1; ev = {1'b1, 4'(m_hold - 1)};
                m_elapsed = 0; m_period = RATE;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(ev);
            else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        if (int'(key_code) == m_cand) begin
            if (m_run <= DEB) m_run++;
        end else begin
            m_cand = int'(key_code);
            m_run  = 1;
        end
    endfunction

    task automatic check_outputs();
        check_eq("valid", 32'(u_if.evt_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check_eq("code", 32'(u_if.evt_code), 32'(q[0][3:0]));
            check_eq("rpt", 32'(u_if.evt_rpt), 32'(q[0][4]));
        end
        check_eq("held", 32'(key_held), 32'(m_held));
        check_eq("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    // One clock edge: advance the model with the applied inputs, then compare.
    task automatic tick();
        model_edge();
        @(posedge mclk);
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset pulse; outputs must clear without waiting for an edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_eq("rst_valid", 32'(u_if.evt_valid), 32'd0);
        check_eq("rst_held", 32'(key_held), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        @(posedge mclk);
        #1;
        rst_n = 1'b1;
    endtask

    int         vcnt;
    logic [0:3] drain_rpt;

    initial begin
        u_if.evt_ready = 1'b0;
        model_reset();
        @(posedge mclk);
        #1;
        do_reset();

        // Single press, no repeat.
        u_if.evt_ready = 1'b1;
        key_code = 5'd5;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (u_if.evt_valid) vcnt++;
            if (i == 5) begin
                check_eq("s1_valid_e5", 32'(u_if.evt_valid), 32'd1);
                check_eq("s1_code_e5", 32'(u_if.evt_code), 32'd4);
                check_eq("s1_rpt_e5", 32'(u_if.evt_rpt), 32'd0);
            end
        end
        check_eq("s1_valid_cycles", 32'(vcnt), 32'd1);
        check_eq("s1_held", 32'(key_held), 32'd1);
        key_code = 5'd0;
        ticks(10);

        // Short burst never becomes stable.
        key_code = 5'd7;
        vcnt = 0;
        for (int i = 0; i < 11; i++) begin
            if (i == 3) key_code = 5'd0;
            tick();
            if (u_if.evt_valid || key_held) vcnt++;
        end
        check_eq("s2_no_event", 32'(vcnt), 32'd0);

        // Auto-repeat and release timing.
        rpt_en = 1'b1;
        key_code = 5'd1;
        for (int i = 0; i < 30; i++) begin
            if (i == 22) key_code = 5'd0;
            tick();
            if (i == 15 || i == 18 || i == 21) begin
                check_eq("s3_rpt_valid", 32'(u_if.evt_valid), 32'd1);
                check_eq("s3_rpt_flag", 32'(u_if.evt_rpt), 32'd1);
                check_eq("s3_rpt_code", 32'(u_if.evt_code), 32'd0);
            end
            if (i == 26) check_eq("s3_held_e26", 32'(key_held), 32'd1);
            if (i == 27) check_eq("s3_held_e27", 32'(key_held), 32'd0);
        end

        // Overflow: four events fill the queue, the fifth is dropped.
        u_if.evt_ready = 1'b0;
        key_code = 5'd2;
        ticks(26);
        check_eq("s4_ovf_set", 32'(ovf), 32'd1);
        rpt_en = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("s4_ovf_clr", 32'(ovf), 32'd0);
        drain_rpt = 4'b0111;
        u_if.evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_eq("s4_drain_valid", 32'(u_if.evt_valid), 32'd1);
            check_eq("s4_drain_code", 32'(u_if.evt_code), 32'd1);
            check_eq("s4_drain_rpt", 32'(u_if.evt_rpt), 32'(drain_rpt[k]));
            tick();
        end
        check_eq("s4_drained", 32'(u_if.evt_valid), 32'd0);
        key_code = 5'd0;
        ticks(10);

        // Rolling key change without passing through zero.
        key_code = 5'd3;
        ticks(8);
        key_code = 5'd9;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("s5_held", 32'(key_held), 32'd1);
        end
        key_code = 5'd0;
        ticks(10);

        // Reset while repeating with three events queued.
        u_if.evt_ready = 1'b0;
        rpt_en = 1'b1;
        key_code = 5'd6;
        ticks(19);
        check_eq("s6_queued", 32'(q.size()), 32'd3);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 4) check_eq("s6_pre_press", 32'(u_if.evt_valid), 32'd0);
        end
        check_eq("s6_fresh_valid", 32'(u_if.evt_valid), 32'd1);
        check_eq("s6_fresh_code", 32'(u_if.evt_code), 32'd5);
        check_eq("s6_fresh_rpt", 32'(u_if.evt_rpt), 32'd0);

        // Random key streams with glitches, backpressure and occasional reset.
        for (int s = 0; s < 150; s++) begin
            int dur;
            if ($urandom_range(0, 3) == 0) key_code = 5'd0;
            else key_code = 5'($urandom_range(1, 16));
            dur = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 40);
            rpt_en = 1'($urandom_range(0, 3) != 0);
            for (int c = 0; c < dur; c++) begin
                u_if.evt_ready = 1'($urandom_range(0, 9) < 6);
                ovf_clr = 1'($urandom_range(0, 19) == 0);
                tick();
            end
            ovf_clr = 1'b0;
            if ($urandom_range(0, 29) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
